secuenciador_mac: RTL and testbench
===================================

Name: secuenciador_mac

Overview:
- Control FSM for the filter multiply-accumulate datapath. It sits between the ADC interface and the product/accumulator registers.
- On each new ADC sample it runs a fixed sequence: shift the sample delay line, clear the accumulator, step through TAPS coefficient/sample pairs, drain the multiplier pipeline, then signal frame completion.
- It generates the ban_Listo flag consumed by the accumulator input register and output stage.

Parameters:
- N, 25: datapath fixed-point width. Carried for consistency only; the controller has no data ports.
- TAPS, 5: number of MAC steps per frame. Range 1..2**ADDR_W.
- ADDR_W, 3: width of sel_tap.
- MULT_LAT, 1: register stages between tap select and product valid. Range 0..3.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- ban_Adc  in  1  new-sample flag from ADC interface. Already synchronous to clk. Level or pulse; only the rising edge is used.
- clr_err  in  1  synchronous clear of overrun.
- en_shift  out  1  one-cycle strobe: shift new sample into delay line.
- clr_acum  out  1  one-cycle strobe: zero the accumulator.
- sel_tap  out  ADDR_W  coefficient/sample select index.
- en_acum  out  1  accumulate enable, aligned to product valid.
- ban_Listo  out  1  one-cycle strobe: frame result valid in accumulator.
- busy  out  1  high whenever state is not IDLE.
- overrun  out  1  sticky: a sample edge arrived while a frame was in progress.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; tap counter=0; drain counter=0; en_acum delay line cleared.
  - All outputs 0.
  - The registered previous ban_Adc is set to 1, so a level held high through reset release does not start a frame.
- Edge detect: edge = ban_Adc & ~adc_q, where adc_q is ban_Adc registered every clk.
- States: IDLE, SHIFT, CLEAR, MAC, DRAIN, DONE. All outputs are registered or decoded from registered state; there is no combinational path from inputs to outputs.
- Timing: cycle 0 is the period after the posedge at which the edge is sampled in IDLE.
  - IDLE -> SHIFT on edge.
  - Cycle 0, SHIFT: en_shift=1, then -> CLEAR.
  - Cycle 1, CLEAR: clr_acum=1, tap counter=0, then -> MAC.
  - Cycles 2..TAPS+1, MAC:
    - sel_tap = tap counter = 0..TAPS-1; counter increments each cycle.
    - Exit to DRAIN after tap TAPS-1, or directly to DONE if MULT_LAT=0.
    - sel_tap holds its last value outside MAC. After reset it is 0.
  - DRAIN: MULT_LAT cycles, then -> DONE.
  - DONE: one cycle, ban_Listo=1.
    - -> SHIFT if edge is present in this cycle (back-to-back frame, no overrun).
    - Otherwise -> IDLE.
- en_acum: the MAC-state valid bit delayed by MULT_LAT registers.
  - Exactly TAPS cycles high per frame, the last one being the final DRAIN cycle.
  - When MULT_LAT=0, en_acum is high exactly in the MAC cycles.
- Latency: ban_Listo occurs in cycle TAPS+2+MULT_LAT. With defaults this is cycle 8, giving a minimum frame period of 9 cycles.
- Overrun:
  - An edge in SHIFT, CLEAR, MAC or DRAIN is dropped; the frame in progress is unaffected; overrun is set to 1.
  - overrun clears only on reset or clr_err=1. If set and clear occur in the same cycle, set wins.
- Reset mid-frame: immediate return to IDLE, all strobes drop, no ban_Listo, no partial accumulation flagged.
- busy = 1 in SHIFT through DONE inclusive.

Test Plan:
- Defaults, single ban_Adc pulse after reset ->
  - en_shift in cycle 0, clr_acum in cycle 1.
  - sel_tap 0,1,2,3,4 in cycles 2-6.
  - en_acum high in cycles 3-7; ban_Listo in cycle 8 only.
  - busy high in cycles 0-8; overrun stays 0.
- ban_Adc held high for 20 cycles -> exactly one frame; no overrun; no second frame until ban_Adc falls and rises again.
- Second ban_Adc edge at cycle 4 of a frame -> frame completes normally with ban_Listo in cycle 8; overrun=1 from the next cycle; no extra frame. clr_err=1 then clears overrun to 0.
- Edge coincident with the DONE cycle -> ban_Listo in cycle 8, en_shift in cycle 9, second ban_Listo in cycle 17; overrun stays 0.
- reset asserted during MAC at tap 2 -> all outputs 0 asynchronously, state IDLE. After release with ban_Adc=1 held, no frame starts until ban_Adc falls and rises again.
- TAPS=3, MULT_LAT=0 -> sel_tap 0,1,2 in cycles 2-4; en_acum in cycles 2-4; ban_Listo in cycle 5; no DRAIN cycle.

Source files
------------

// File: rtl/secuenciador_mac.sv
// secuenciador_mac
// Control sequencer for the filter multiply-accumulate datapath.
// On each rising edge of ban_Adc it runs one frame:
//   SHIFT (en_shift) -> CLEAR (clr_acum) -> MAC (sel_tap 0..TAPS-1)
//   -> DRAIN (MULT_LAT cycles) -> DONE (ban_Listo).
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous active-low reset
//   ban_Adc   new-sample flag, synchronous to clk, rising edge starts a frame
//   clr_err   synchronous clear of the sticky overrun flag
//   en_shift  strobe: shift the new sample into the delay line
//   clr_acum  strobe: zero the accumulator
//   sel_tap   coefficient/sample select index
//   en_acum   accumulate enable, aligned to product valid
//   ban_Listo strobe: frame result valid
//   busy      frame in progress
//   overrun   sticky: a sample edge arrived while a frame was running
module secuenciador_mac #(
    parameter int N        = 25,
    parameter int TAPS     = 5,
    parameter int ADDR_W   = 3,
    parameter int MULT_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ban_Adc,
    input  logic              clr_err,
    output logic              en_shift,
    output logic              clr_acum,
    output logic [ADDR_W-1:0] sel_tap,
    output logic              en_acum,
    output logic              ban_Listo,
    output logic              busy,
    output logic              overrun
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SHIFT = 3'd1,
        CLEAR = 3'd2,
        MAC   = 3'd3,
        DRAIN = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t            state_r;
    logic [ADDR_W-1:0] tap_r;
    logic [1:0]        drain_r;
    logic              adc_q_r;
    logic              en_shift_r;
    logic              clr_acum_r;
    logic              mac_r;
    logic              listo_r;
    logic              overrun_r;
    logic              edge_s;
    logic              in_frame_s;

    assign edge_s     = ban_Adc & ~adc_q_r;
    // DONE is excluded: an edge there starts the next frame back-to-back.
    assign in_frame_s = (state_r == SHIFT) || (state_r == CLEAR) ||
                        (state_r == MAC)   || (state_r == DRAIN);

    // Frame sequencer: state, tap/drain counters and registered strobes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= IDLE;
            tap_r      <= '0;
            drain_r    <= 2'd0;
            adc_q_r    <= 1'b1;   // a level held through reset is not an edge
            en_shift_r <= 1'b0;
            clr_acum_r <= 1'b0;
            mac_r      <= 1'b0;
            listo_r    <= 1'b0;
        end else begin
            adc_q_r    <= ban_Adc;
            en_shift_r <= 1'b0;
            clr_acum_r <= 1'b0;
            listo_r    <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (edge_s) begin
                        state_r    <= SHIFT;
                        en_shift_r <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                SHIFT: begin
                    state_r    <= CLEAR;
                    clr_acum_r <= 1'b1;
                end
                CLEAR: begin
                    state_r <= MAC;
                    tap_r   <= '0;
                    mac_r   <= 1'b1;
                end
                MAC: begin
                    if (tap_r == ADDR_W'(TAPS - 1)) begin
                        mac_r <= 1'b0;
                        if (MULT_LAT == 0) begin
                            state_r <= DONE;
                            listo_r <= 1'b1;
                        end else begin
                            state_r <= DRAIN;
                            drain_r <= 2'd0;
                        end
                    end else begin
                        tap_r <= tap_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                    end
                end
                DRAIN: begin
                    if (drain_r == 2'(MULT_LAT - 1)) begin
                        state_r <= DONE;
                        listo_r <= 1'b1;
                    end else begin
                        drain_r <= drain_r + 2'd1;
                    end
                end
                DONE: begin
                    if (edge_s) begin
                        state_r    <= SHIFT;
                        en_shift_r <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    mac_r   <= 1'b0;
                end
            endcase
        end
    end

    // Sticky overrun: set on a dropped edge, set has priority over clr_err.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overrun_r <= 1'b0;
        end else if (edge_s && in_frame_s) begin
            overrun_r <= 1'b1;
        end else if (clr_err) begin
            overrun_r <= 1'b0;
        end else begin
            overrun_r <= overrun_r;
        end
    end

    // en_acum is the MAC-state valid bit delayed to match the multiplier.
    generate
        if (MULT_LAT == 0) begin : g_no_lat
            assign en_acum = mac_r;
        end else begin : g_lat
            logic [MULT_LAT-1:0] pipe_r;
            // Valid-bit delay line matching the multiplier register stages.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    pipe_r <= '0;
                end else begin
                    pipe_r[0] <= mac_r;
                    for (int i = 1; i < MULT_LAT; i++) begin
                        pipe_r[i] <= pipe_r[i-1];
                    end
                end
            end
            assign en_acum = pipe_r[MULT_LAT-1];
        end
    endgenerate

    assign en_shift  = en_shift_r;
    assign clr_acum  = clr_acum_r;
    assign sel_tap   = tap_r;
    assign ban_Listo = listo_r;
    assign busy      = (state_r != IDLE);
    assign overrun   = overrun_r;

endmodule

// File: tb/tb_secuenciador_mac.sv
module tb_secuenciador_mac;

    logic       clk;
    logic       reset;
    logic       ban_Adc;
    logic       clr_err;
    logic       en_shift, clr_acum, en_acum, ban_Listo, busy, overrun;
    logic [2:0] sel_tap;

    logic       adc2;
    logic       en_shift2, clr_acum2, en_acum2, ban_Listo2, busy2, overrun2;
    logic [2:0] sel_tap2;

    int total_checks;
    int passed_checks;

    secuenciador_mac #(.N(25), .TAPS(5), .ADDR_W(3), .MULT_LAT(1)) dut (
        .clk(clk), .reset(reset), .ban_Adc(ban_Adc), .clr_err(clr_err),
        .en_shift(en_shift), .clr_acum(clr_acum), .sel_tap(sel_tap),
        .en_acum(en_acum), .ban_Listo(ban_Listo), .busy(busy), .overrun(overrun)
    );

    secuenciador_mac #(.N(25), .TAPS(3), .ADDR_W(3), .MULT_LAT(0)) dut2 (
        .clk(clk), .reset(reset), .ban_Adc(adc2), .clr_err(clr_err),
        .en_shift(en_shift2), .clr_acum(clr_acum2), .sel_tap(sel_tap2),
        .en_acum(en_acum2), .ban_Listo(ban_Listo2), .busy(busy2), .overrun(overrun2)
    );

    // Observed outputs packed as {en_shift, clr_acum, sel_tap, en_acum, ban_Listo, busy, overrun}
    logic [8:0] obs1, obs2;
    assign obs1 = {en_shift, clr_acum, sel_tap, en_acum, ban_Listo, busy, overrun};
    assign obs2 = {en_shift2, clr_acum2, sel_tap2, en_acum2, ban_Listo2, busy2, overrun2};

    typedef struct packed {
        logic       sh;
        logic       clr;
        logic       hold;   // sel_tap still shows the previous frame's value
        logic [2:0] sel;
        logic       acum;
        logic       listo;
        logic       busy;
    } row_t;

    row_t tbl[9];
    row_t tbl2[7];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string name, input int cyc, input logic [8:0] act, input logic [8:0] exp);
        total_checks++;
        if (act !== exp) begin
            $display("FAIL %s cycle %0d: got {sh,clr,sel,acum,listo,busy,ovr}=%b expected %b",
                     name, cyc, act, exp);
        end else begin
            passed_checks++;
        end
    endtask

    function automatic logic [8:0] exp_row(input row_t r, input logic [2:0] prev_sel, input logic ovr);
        return {r.sh, r.clr, (r.hold ? prev_sel : r.sel), r.acum, r.listo, r.busy, ovr};
    endfunction

    // Default-parameter frame: cycles 0..8 against tbl. If do_start, raise
    // ban_Adc so the edge is sampled at the next posedge (cycle 0 follows).
    // Unless hold, ban_Adc is driven high only in cycle second_c.
    task automatic run_frame(input string name, input logic [2:0] prev_sel, input bit do_start,
                             input bit hold, input int second_c, input int ovr_from);
        if (do_start) begin
            @(negedge clk);
            ban_Adc = 1'b1;
            @(posedge clk);
        end
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            cmp(name, c, obs1, exp_row(tbl[c], prev_sel, (c >= ovr_from)));
            if (!hold) ban_Adc = (c == second_c);
        end
    endtask

    task automatic idle_check(input string name, input int n, input logic [2:0] sel, input logic ovr);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cmp(name, i, obs1, {1'b0, 1'b0, sel, 1'b0, 1'b0, 1'b0, ovr});
        end
    endtask

    initial begin
        total_checks  = 0;
        passed_checks = 0;
        reset   = 1'b0;
        ban_Adc = 1'b0;
        clr_err = 1'b0;
        adc2    = 1'b0;

        //                 sh    clr   hold  sel   acum  listo busy
        tbl[0] = '{1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1};
        tbl[1] = '{1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1};
        tbl[2] = '{1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1};
        tbl[3] = '{1'b0, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0, 1'b1};
        tbl[4] = '{1'b0, 1'b0, 1'b0, 3'd2, 1'b1, 1'b0, 1'b1};
        tbl[5] = '{1'b0, 1'b0, 1'b0, 3'd3, 1'b1, 1'b0, 1'b1};
        tbl[6] = '{1'b0, 1'b0, 1'b0, 3'd4, 1'b1, 1'b0, 1'b1};
        tbl[7] = '{1'b0, 1'b0, 1'b0, 3'd4, 1'b1, 1'b0, 1'b1};
        tbl[8] = '{1'b0, 1'b0, 1'b0, 3'd4, 1'b0, 1'b1, 1'b1};

        // TAPS=3, MULT_LAT=0: no DRAIN, ban_Listo in cycle 5
        tbl2[0] = '{1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1};
        tbl2[1] = '{1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1};
        tbl2[2] = '{1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1};
        tbl2[3] = '{1'b0, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0, 1'b1};
        tbl2[4] = '{1'b0, 1'b0, 1'b0, 3'd2, 1'b1, 1'b0, 1'b1};
        tbl2[5] = '{1'b0, 1'b0, 1'b0, 3'd2, 1'b0, 1'b1, 1'b1};
        tbl2[6] = '{1'b0, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0};

        // Reset state
        @(negedge clk);
        @(negedge clk);
        cmp("reset_state", 0, obs1, 9'b0);
        cmp("reset_state2", 0, obs2, 9'b0);
        reset = 1'b1;
        idle_check("post_reset_idle", 2, 3'd0, 1'b0);

        // Single pulse
        run_frame("pulse", 3'd0, 1'b1, 1'b0, -1, 99);
        idle_check("pulse_after", 2, 3'd4, 1'b0);

        // Level held high for 20 cycles: one frame only
        run_frame("held", 3'd4, 1'b1, 1'b1, -1, 99);
        idle_check("held_after", 11, 3'd4, 1'b0);
        ban_Adc = 1'b0;
        idle_check("held_fall", 2, 3'd4, 1'b0);

        // Second edge at cycle 4: dropped, overrun from cycle 5
        run_frame("ovr", 3'd4, 1'b1, 1'b0, 4, 5);
        idle_check("ovr_after", 1, 3'd4, 1'b1);
        clr_err = 1'b1;
        idle_check("ovr_clr", 1, 3'd4, 1'b0);
        clr_err = 1'b0;
        idle_check("ovr_clr_idle", 1, 3'd4, 1'b0);

        // Edge during DONE: back-to-back frame starting cycle 9
        run_frame("b2b_a", 3'd4, 1'b1, 1'b0, 8, 99);
        run_frame("b2b_b", 3'd4, 1'b0, 1'b0, -1, 99);
        idle_check("b2b_after", 2, 3'd4, 1'b0);

        // Reset during MAC at tap 2, ban_Adc held high
        @(negedge clk);
        ban_Adc = 1'b1;
        @(posedge clk);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            cmp("rst_mid_pre", c, obs1, exp_row(tbl[c], 3'd4, 1'b0));
        end
        reset = 1'b0;
        #1;
        cmp("rst_mid_async", 4, obs1, 9'b0);
        @(negedge clk);
        reset = 1'b1;
        idle_check("rst_mid_held", 4, 3'd0, 1'b0);
        ban_Adc = 1'b0;
        idle_check("rst_mid_fall", 1, 3'd0, 1'b0);
        run_frame("rst_mid_restart", 3'd0, 1'b1, 1'b0, -1, 99);

        // TAPS=3, MULT_LAT=0 instance
        @(negedge clk);
        adc2 = 1'b1;
        @(posedge clk);
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            cmp("taps3_lat0", c, obs2, exp_row(tbl2[c], 3'd0, 1'b0));
            adc2 = 1'b0;
        end

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
